// File: rtl/sha_256_pkg.sv
// Shared definitions for the SHA-256 wrapper bus sequencer: the register map,
// the CTRL/STATUS bit positions, and the sequencer state encoding.
package sha_256_pkg;

    localparam logic [7:0] ADDR_NAME0   = 8'h00;
    localparam logic [7:0] ADDR_CTRL    = 8'h08;
    localparam logic [7:0] ADDR_STATUS  = 8'h09;
    localparam logic [7:0] ADDR_BLOCK0  = 8'h10;
    localparam logic [7:0] ADDR_DIGEST0 = 8'h20;

    localparam int CTRL_INIT_BIT    = 0;
    localparam int CTRL_NEXT_BIT    = 1;
    localparam int CTRL_MODE_BIT    = 2;
    localparam int STATUS_READY_BIT = 0;
    localparam int STATUS_VALID_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_BLK,
        ST_WR_CTRL,
        ST_HOLD,
        ST_POLL,
        ST_RD_DIG,
        ST_OUT
    } seq_state_t;

    // First block of a message starts with init, every other block chains with next.
    function automatic logic [31:0] ctrl_word(input logic first);
        logic [31:0] w;
        w = '0;
        w[CTRL_INIT_BIT] = first;
        w[CTRL_NEXT_BIT] = ~first;
        w[CTRL_MODE_BIT] = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/sha_256_bus_if.sv
// Registers one bus access per cycle towards the wrapper and flags the cycles
// whose read data is to be captured at the following edge.
module sha_256_bus_if (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        bus_cs,
    output logic        bus_we,
    output logic [7:0]  bus_addr,
    output logic [31:0] bus_wdata,
    output logic        rd_strobe
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus_cs    <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            bus_cs <= req_valid;
            bus_we <= req_valid && req_we;
            // Address and data hold their last value while the bus is idle.
            if (req_valid) begin
                bus_addr  <= req_addr;
                bus_wdata <= req_wdata;
            end
        end
    end

    assign rd_strobe = bus_cs && !bus_we;

endmodule

// File: rtl/sha_256_seq.sv
// Streams pre-padded 512-bit blocks into the SHA-256 wrapper, kicks init/next,
// polls for completion and returns the digest after the last block of a message.
module sha_256_seq
    import sha_256_pkg::*;
#(
    parameter int START_DLY = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [511:0] s_block,
    input  logic         s_first,
    input  logic         s_last,
    output logic         d_valid,
    input  logic         d_ready,
    output logic [255:0] d_digest,
    output logic         bus_cs,
    output logic         bus_we,
    output logic [7:0]   bus_addr,
    output logic [31:0]  bus_wdata,
    input  logic [31:0]  bus_rdata,
    output logic         busy,
    output logic         err
);

    seq_state_t   state_reg, state_next;
    logic [3:0]   idx_reg, idx_next;
    logic [15:0]  cnt_reg, cnt_next;
    logic [511:0] blk_reg;
    logic         first_reg, last_reg;
    logic         s_ready_reg, d_valid_reg, busy_reg, err_reg;
    logic [255:0] digest_reg;

    logic         accept, timeout_hit, status_done, rd_strobe;
    logic         req_valid, req_we;
    logic [7:0]   req_addr;
    logic [31:0]  req_wdata;
    logic [31:0]  blk_word;

    assign accept   = s_valid && s_ready_reg;
    assign blk_word = blk_reg[9'd511 - {idx_reg, 5'd0} -: 32];

    // Only the final block of a message must also wait for the digest to be valid.
    assign status_done = rd_strobe && (bus_addr == ADDR_STATUS) &&
                         bus_rdata[STATUS_READY_BIT] &&
                         (!last_reg || bus_rdata[STATUS_VALID_BIT]);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        cnt_next    = cnt_reg;
        timeout_hit = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_WR_BLK;
                    idx_next   = '0;
                end
            end
            ST_WR_BLK: begin
                idx_next = idx_reg + 4'd1;
                if (idx_reg == 4'd15) state_next = ST_WR_CTRL;
            end
            ST_WR_CTRL: begin
                state_next = ST_HOLD;
                cnt_next   = '0;
            end
            ST_HOLD: begin
                if (cnt_reg == 16'(START_DLY - 1)) begin
                    state_next = ST_POLL;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_POLL: begin
                if (status_done) begin
                    state_next = last_reg ? ST_RD_DIG : ST_IDLE;
                    idx_next   = '0;
                end else if (cnt_reg == 16'(TIMEOUT - 1)) begin
                    state_next  = ST_IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_RD_DIG: begin
                // idx 8 is the edge that captures the eighth read, no new access.
                if (idx_reg == 4'd8) state_next = ST_OUT;
                else                 idx_next   = idx_reg + 4'd1;
            end
            ST_OUT: begin
                if (d_ready && d_valid_reg) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = ADDR_STATUS;
        req_wdata = '0;
        case (state_reg)
            ST_WR_BLK: begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = ADDR_BLOCK0 | {4'd0, idx_reg};
                req_wdata = blk_word;
            end
            ST_WR_CTRL: begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = ADDR_CTRL;
                req_wdata = ctrl_word(first_reg);
            end
            ST_POLL: begin
                req_valid = (state_next == ST_POLL);
                req_addr  = ADDR_STATUS;
            end
            ST_RD_DIG: begin
                req_valid = !idx_reg[3];
                req_addr  = ADDR_DIGEST0 | {5'd0, idx_reg[2:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            blk_reg     <= '0;
            first_reg   <= 1'b0;
            last_reg    <= 1'b0;
            s_ready_reg <= 1'b1;
            d_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
            err_reg     <= 1'b0;
            digest_reg  <= '0;
        end else begin
            if (accept) begin
                blk_reg   <= s_block;
                first_reg <= s_first;
                last_reg  <= s_last;
            end
            s_ready_reg <= (state_next == ST_IDLE);
            busy_reg    <= (state_next != ST_IDLE);
            d_valid_reg <= (state_next == ST_OUT);
            err_reg     <= timeout_hit;
            if (rd_strobe && (bus_addr[7:3] == ADDR_DIGEST0[7:3]))
                digest_reg[8'd255 - {bus_addr[2:0], 5'd0} -: 32] <= bus_rdata;
        end
    end

    sha_256_bus_if u_bus_if (
        .clk       (clk),
        .n_rst     (n_rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .bus_cs    (bus_cs),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .rd_strobe (rd_strobe)
    );

    assign s_ready  = s_ready_reg;
    assign d_valid  = d_valid_reg;
    assign d_digest = digest_reg;
    assign busy     = busy_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_sha_256_seq.sv
// Bench for sha_256_seq with a behavioural SHA-256 wrapper on the register bus.
module tb_sha_256_seq;

    localparam int START_DLY = 4;
    localparam int TIMEOUT   = 16;
    localparam int MODEL_LAT = 8;

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0] TWO_BLK1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_BLK2 = {480'd0, 32'h000001c0};
    localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
        logic [31:0]  exp_ctrl;
        logic         exp_dv;
        logic [255:0] exp_digest;
    } vec_t;

    logic         clk, n_rst;
    logic         s_valid, s_ready, s_first, s_last;
    logic [511:0] s_block;
    logic         d_valid, d_ready;
    logic [255:0] d_digest;
    logic         bus_cs, bus_we;
    logic [7:0]   bus_addr;
    logic [31:0]  bus_wdata, bus_rdata;
    logic         busy, err;

    int tests = 0;
    int fails = 0;

    sha_256_seq #(.START_DLY(START_DLY), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_block   (s_block),
        .s_first   (s_first),
        .s_last    (s_last),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_digest  (d_digest),
        .bus_cs    (bus_cs),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Wrapper model: block registers, init/next compression, delayed ready/valid.
    logic [31:0]  wblk [16];
    logic [511:0] wcat;
    logic [255:0] hreg    = '0;
    logic         m_ready = 1'b1;
    logic         m_valid = 1'b0;
    int           m_cnt   = 0;
    logic         stuck   = 1'b0;

    always_comb begin
        wcat = '0;
        for (int i = 0; i < 16; i++) wcat[511 - 32*i -: 32] = wblk[i];
    end

    always @(posedge clk) begin
        if (bus_cs && bus_we && bus_addr[7:4] == 4'h1) wblk[bus_addr[3:0]] <= bus_wdata;
        if (bus_cs && bus_we && bus_addr == 8'h08 && (bus_wdata[0] || bus_wdata[1])) begin
            hreg    <= sha_compress(bus_wdata[0] ? IV : hreg, wcat);
            m_ready <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= MODEL_LAT;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_ready <= 1'b1;
                m_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        bus_rdata = '0;
        if (bus_cs && !bus_we) begin
            if (bus_addr == 8'h09)
                bus_rdata = stuck ? 32'd0 : {30'd0, m_valid, m_ready};
            else if (bus_addr[7:3] == 5'b00100)
                bus_rdata = hreg[255 - 32*int'(bus_addr[2:0]) -: 32];
        end
    end

    // Bus monitor: counts accesses and checks the address order of each block.
    int          cyc = 0, total_blk = 0, total_ctrl = 0, total_dvrise = 0, total_err = 0;
    int          proto_bad = 0, ctrl_cyc = 0, err_cyc = 0, phase = 4;
    logic [31:0] last_ctrl = '0;
    logic [7:0]  exp_addr  = 8'h10;
    logic        dv_prev   = 1'b0;

    always @(negedge clk) begin
        cyc     <= cyc + 1;
        dv_prev <= d_valid;
        if (d_valid && !dv_prev) total_dvrise <= total_dvrise + 1;
        if (err) begin
            total_err <= total_err + 1;
            err_cyc   <= cyc;
        end
        if (bus_we && !bus_cs) proto_bad <= proto_bad + 1;
        if (bus_cs) begin
            if (bus_we && bus_addr[7:4] == 4'h1) total_blk <= total_blk + 1;
            if (bus_we && bus_addr == 8'h08) begin
                total_ctrl <= total_ctrl + 1;
                last_ctrl  <= bus_wdata;
                ctrl_cyc   <= cyc;
            end
            if (bus_we && bus_addr == 8'h10) begin
                phase    <= 0;
                exp_addr <= 8'h11;
            end else begin
                case (phase)
                    0: if (!bus_we || bus_addr != exp_addr) proto_bad <= proto_bad + 1;
                       else begin
                           exp_addr <= exp_addr + 8'd1;
                           if (bus_addr == 8'h1f) phase <= 1;
                       end
                    1: if (!bus_we || bus_addr != 8'h08) proto_bad <= proto_bad + 1;
                       else phase <= 2;
                    2: if (bus_we) proto_bad <= proto_bad + 1;
                       else if (bus_addr == 8'h20) begin
                           phase    <= 3;
                           exp_addr <= 8'h21;
                       end else if (bus_addr != 8'h09) proto_bad <= proto_bad + 1;
                    3: if (bus_we || bus_addr != exp_addr) proto_bad <= proto_bad + 1;
                       else begin
                           exp_addr <= exp_addr + 8'd1;
                           if (bus_addr == 8'h27) phase <= 4;
                       end
                    default: proto_bad <= proto_bad + 1;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_block(input logic [511:0] blk, input logic first, input logic last);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("s_ready before accept", 256'(ok), 256'(1));
        s_block = blk;
        s_first = first;
        s_last  = last;
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_done(output logic dv, output logic done);
        dv   = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (d_valid) begin
                dv   = 1'b1;
                done = 1'b1;
                break;
            end
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        check("transaction completes", 256'(done), 256'(1));
    endtask

    task automatic take_digest();
        d_ready = 1'b1;
        @(posedge clk);
        #1 d_ready = 1'b0;
        @(negedge clk);
        check("d_valid drops after handshake", 256'(d_valid), 256'(0));
        check("s_ready back after handshake", 256'(s_ready), 256'(1));
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int   b0, c0, r0;
        logic dv, done;
        b0 = total_blk;
        c0 = total_ctrl;
        r0 = total_dvrise;
        send_block(v.blk, v.first, v.last);
        wait_done(dv, done);
        check("block writes", 256'(total_blk - b0), 256'(16));
        check("ctrl writes", 256'(total_ctrl - c0), 256'(1));
        check("ctrl word", 256'(last_ctrl), 256'(v.exp_ctrl));
        check("d_valid presence", 256'(dv), 256'(v.exp_dv));
        if (dv) begin
            check("digest", d_digest, v.exp_digest);
            take_digest();
        end
        check("d_valid rises", 256'(total_dvrise - r0), 256'(v.exp_dv));
        $display("[TB] vec %0d first=%0d last=%0d ctrl=%08h d_valid=%0d digest=%064h",
                 n, v.first, v.last, last_ctrl, dv, d_digest);
    endtask

    vec_t vecs [5];
    vec_t abc_v;

    initial begin
        int   b0, e0, r0, bp_bad;
        logic dv, done, found;

        n_rst   = 1'b0;
        s_valid = 1'b0;
        s_block = '0;
        s_first = 1'b0;
        s_last  = 1'b0;
        d_ready = 1'b0;

        abc_v   = '{blk: ABC_BLK, first: 1'b1, last: 1'b1, exp_ctrl: 32'h1, exp_dv: 1'b1, exp_digest: ABC_DIG};
        vecs[0] = abc_v;
        vecs[1] = '{blk: TWO_BLK1, first: 1'b1, last: 1'b0, exp_ctrl: 32'h1, exp_dv: 1'b0, exp_digest: '0};
        vecs[2] = '{blk: TWO_BLK2, first: 1'b0, last: 1'b1, exp_ctrl: 32'h2, exp_dv: 1'b1, exp_digest: TWO_DIG};
        vecs[3] = '{blk: '0,       first: 1'b0, last: 1'b0, exp_ctrl: 32'h2, exp_dv: 1'b0, exp_digest: '0};
        vecs[4] = abc_v;

        repeat (3) @(negedge clk);
        check("reset s_ready", 256'(s_ready), 256'(1));
        check("reset d_valid/busy/err", 256'({d_valid, busy, err}), 256'(0));
        check("reset bus", 256'({bus_cs, bus_we, bus_addr, bus_wdata}), 256'(0));
        check("reset d_digest", d_digest, 256'(0));
        n_rst = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Digest consumer stalls: output must hold and no new block may enter.
        send_block(ABC_BLK, 1'b1, 1'b1);
        wait_done(dv, done);
        check("backpressure d_valid", 256'(dv), 256'(1));
        b0      = total_blk;
        bp_bad  = 0;
        s_block = TWO_BLK1;
        s_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!d_valid || d_digest !== ABC_DIG || s_ready) bp_bad++;
        end
        s_valid = 1'b0;
        check("backpressure hold", 256'(bp_bad), 256'(0));
        check("backpressure no block writes", 256'(total_blk - b0), 256'(0));
        take_digest();
        $display("[TB] backpressure 50 cycles, digest=%064h", d_digest);

        // Wrapper never reports ready: poll must give up with a single err pulse.
        stuck = 1'b1;
        e0 = total_err;
        r0 = total_dvrise;
        send_block(ABC_BLK, 1'b1, 1'b1);
        wait_done(dv, done);
        check("timeout no d_valid", 256'(dv), 256'(0));
        @(negedge clk);
        check("timeout busy/s_ready/err after", 256'({busy, s_ready, err}), 256'(3'b010));
        check("timeout err pulses", 256'(total_err - e0), 256'(1));
        check("timeout err timing", 256'(err_cyc - ctrl_cyc), 256'(START_DLY + TIMEOUT));
        check("timeout d_valid rises", 256'(total_dvrise - r0), 256'(0));
        stuck = 1'b0;
        $display("[TB] timeout err after %0d cycles", err_cyc - ctrl_cyc);

        // Reset while block word 7 is on the bus, then a clean run.
        send_block(ABC_BLK, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus_cs && bus_addr == 8'h17) begin
                found = 1'b1;
                break;
            end
        end
        check("reached block word 7", 256'(found), 256'(1));
        #2 n_rst = 1'b0;
        #1;
        check("async reset bus", 256'({bus_cs, bus_we, bus_addr, bus_wdata}), 256'(0));
        check("async reset flags", 256'({s_ready, busy, d_valid, err}), 256'(4'b1000));
        check("async reset d_digest", d_digest, 256'(0));
        @(negedge clk);
        n_rst = 1'b1;
        $display("[TB] reset during block write at addr 17");
        run_vec(abc_v, 5);

        check("bus protocol violations", 256'(proto_bad), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
